// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - streams real samples into the four RAM_A banks and hands frames to the FFT core
module fft_input_loader #(
  parameter int N_POINTS = 2048,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iSAMPLE,
  input  logic              iOFFSET_BIN,
  output logic              oREADY,
  input  logic              iFFT_RDY,
  input  logic              iRELEASE,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W-1:0] oADDR_WR_0,
  output logic [ADDR_W-1:0] oADDR_WR_1,
  output logic [ADDR_W-1:0] oADDR_WR_2,
  output logic [ADDR_W-1:0] oADDR_WR_3,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3,
  output logic              oSTART,
  output logic              oBUSY,
  output logic [15:0]       oFRAME_CNT
);

  // Sample index: low two bits pick the bank, the rest is the bank address.
  localparam int CNT_W = ADDR_W + 2;
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(N_POINTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_FFT,
    WAIT_REL
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  n;
  logic              full;        // final sample of the frame has been accepted
  logic              accept;
  logic              frame_done;  // release taken, banks handed back to the loader
  logic              start_entry;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q [4];
  logic [3:0]        we_q;
  logic              start_q;
  logic              busy_q;
  logic [15:0]       frame_cnt_q;

  // Ready is the only combinational output; it falls as soon as the last sample is taken.
  assign oREADY = (state == LOAD) && !full;
  assign accept = iVALID && oREADY;

  // Next-state logic; pulses outside their waiting state are simply not looked at.
  always_comb begin
    next_state  = state;
    frame_done  = 1'b0;
    start_entry = 1'b0;
    case (state)
      IDLE:     next_state = LOAD;
      LOAD: begin
        // full is set by the final acceptance, so this cycle carries the last write
        if (full) begin
          next_state  = START;
          start_entry = 1'b1;
        end
      end
      START:    next_state = WAIT_FFT;
      WAIT_FFT: if (iFFT_RDY) next_state = WAIT_REL;
      WAIT_REL: begin
        if (iRELEASE) begin
          next_state = LOAD;
          frame_done = 1'b1;
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state <= IDLE;
    else        state <= next_state;
  end

  // Sample counter; it parks on the last index until the banks are released.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      n    <= '0;
      full <= 1'b0;
    end else if (frame_done) begin
      n    <= '0;
      full <= 1'b0;
    end else if (accept) begin
      if (n == LAST_N) full <= 1'b1;
      else             n    <= n + 1'b1;
    end
  end

  // Registered load port: one bank write per accepted sample, unselected addresses hold.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      data_q <= '0;
      we_q   <= '0;
      for (int i = 0; i < 4; i++) addr_q[i] <= '0;
    end else begin
      we_q <= '0;
      if (accept) begin
        data_q           <= {iSAMPLE[DATA_W-1] ^ iOFFSET_BIN, iSAMPLE[DATA_W-2:0]};
        we_q[n[1:0]]     <= 1'b1;
        addr_q[n[1:0]]   <= n[CNT_W-1:2];
      end
    end
  end

  // Start pulse, busy flag and completed-frame counter.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      start_q <= start_entry;
      if (start_entry) begin
        busy_q <= 1'b1;
      end else if (frame_done) begin
        busy_q      <= 1'b0;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign oDATA      = data_q;
  assign oADDR_WR_0 = addr_q[0];
  assign oADDR_WR_1 = addr_q[1];
  assign oADDR_WR_2 = addr_q[2];
  assign oADDR_WR_3 = addr_q[3];
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oSTART     = start_q;
  assign oBUSY      = busy_q;
  assign oFRAME_CNT = frame_cnt_q;

endmodule
